// File: rtl/lift_timer_pkg.sv
// Shared types and constants for the elevator door/travel timer.
package lift_timer_pkg;

  localparam int unsigned STATE_W        = 2;
  localparam int unsigned PRESCALE_CNT_W = 16;
  localparam int unsigned PRESCALE_MIN   = 2;
  localparam int unsigned PRESCALE_MAX   = 65535;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } timer_state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// Tick divider: emits one tick every PRESCALE clocks while not held.
module timer_prescaler
  import lift_timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  output logic tick
);

  localparam logic [PRESCALE_CNT_W-1:0] LAST = PRESCALE_CNT_W'(PRESCALE - 1);

  logic [PRESCALE_CNT_W-1:0] cnt_q;

  // Free-running divider, frozen by hold and zeroed on clear/reset.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (!hold) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + PRESCALE_CNT_W'(1);
    end
  end

  // Tick coincides with the wrap edge so latency is exactly PRESCALE clocks.
  assign tick = !hold && !clear && (cnt_q == LAST);

endmodule

// File: rtl/elevator_timer.sv
// Elevator timer: one-shot or periodic countdown with pause, abort and
// restart. Optional tick prescaler enabled by defining TIMER_PRESCALE_EN.
module elevator_timer
  import lift_timer_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 10
) (
  input  logic             i_clock,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_pause,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_period,
  output logic             o_done,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_count
);

  // Reject out-of-range prescale at elaboration.
  if (PRESCALE < PRESCALE_MIN || PRESCALE > PRESCALE_MAX) begin : g_bad_prescale
    $error("elevator_timer: PRESCALE out of range");
  end

  timer_state_t     state_q, state_d;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             mode_q, mode_d;
  logic             done_d;
  logic             busy_d;
  logic             start_ok;
  logic             tick;

  // A start with a zero period is treated as no start at all.
  assign start_ok = i_start && (i_period != '0);

`ifdef TIMER_PRESCALE_EN
  // Divider only advances while counting; pause or idle freezes it.
  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock (i_clock),
    .reset (i_rst),
    .clear (i_abort || start_ok),
    .hold  (i_pause || (state_q == IDLE)),
    .tick  (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // State and registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      state_q  <= IDLE;
      o_count  <= '0;
      o_done   <= 1'b0;
      o_busy   <= 1'b0;
      period_q <= '0;
      mode_q   <= MODE_ONESHOT;
    end else begin
      state_q  <= state_d;
      o_count  <= count_d;
      o_done   <= done_d;
      o_busy   <= busy_d;
      period_q <= period_d;
      mode_q   <= mode_d;
    end
  end

  // Next state: abort > start > pause > tick.
  always_comb begin
    state_d  = state_q;
    count_d  = o_count;
    period_d = period_q;
    mode_d   = mode_q;
    done_d   = 1'b0;

    if (i_abort) begin
      state_d = IDLE;
      count_d = '0;
    end else if (start_ok) begin
      period_d = i_period;
      mode_d   = i_mode;
      count_d  = i_period;
      state_d  = i_pause ? PAUSE : RUN;
    end else begin
      unique case (state_q)
        RUN, PAUSE: begin
          if (i_pause) begin
            state_d = PAUSE;
          end else begin
            state_d = RUN;
            if (tick) begin
              if (o_count > WIDTH'(1)) begin
                count_d = o_count - WIDTH'(1);
              end else if (o_count == WIDTH'(1)) begin
                done_d = 1'b1;
                if (mode_q == MODE_PERIODIC) begin
                  count_d = period_q;
                end else begin
                  count_d = '0;
                  state_d = IDLE;
                end
              end else begin
                // Count already exhausted; never wrap below zero.
                count_d = '0;
                state_d = IDLE;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

endmodule

// File: doc/elevator_timer.md
ELEVATOR_TIMER -- requirements
Module: elevator_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of period and count.
REQ-002 SHALL have parameter PRESCALE, default 10, clocks per tick; used only when TIMER_PRESCALE_EN is defined; legal range 2..65535.
REQ-003 SHALL have port i_clock, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port i_start, input, 1, load i_period and run; restarts if already running.
REQ-006 SHALL have port i_abort, input, 1, stop and clear to IDLE.
REQ-007 SHALL have port i_pause, input, 1, freeze count while high.
REQ-008 SHALL have port i_mode, input, 1, sampled on start: 0 one-shot, 1 periodic auto-reload.
REQ-009 SHALL have port i_period, input, WIDTH, tick count N, sampled on start.
REQ-010 SHALL have port o_done, output, 1, single-cycle expiry pulse.
REQ-011 SHALL have port o_busy, output, 1, high in RUN or PAUSE.
REQ-012 SHALL have port o_count, output, WIDTH, remaining ticks.

Function
REQ-013 SHALL implement states IDLE, RUN, PAUSE; o_busy registered, equal to (state != IDLE).
REQ-014 SHALL apply per-edge priority: i_rst > i_abort > i_start > i_pause > tick.
REQ-015 On i_start with N>=1, SHALL latch N and mode, set o_count=N, enter RUN (PAUSE if i_pause high), with no o_done pulse on that edge.
REQ-016 On i_start with N=0, SHALL ignore the start: state, count and latched values unchanged.
REQ-017 In RUN, each tick with o_count>1 SHALL decrement o_count by 1.
REQ-018 In RUN, a tick with o_count==1 SHALL assert o_done for exactly one cycle; one-shot: o_count=0, go IDLE; periodic: o_count=latched N, stay RUN.
REQ-019 Without prescale, o_done SHALL rise exactly N clocks after the start edge; periodic pulses every N clocks thereafter.
REQ-020 i_start in RUN or PAUSE SHALL reload from the current i_period/i_mode (door-reopen extension) and suppress any o_done on that edge.
REQ-021 i_pause high in RUN SHALL enter PAUSE holding o_count; i_pause low in PAUSE SHALL return to RUN; ticks are not counted in PAUSE.
REQ-022 i_abort SHALL force IDLE, o_count=0, o_done=0 on the next edge from any state.
REQ-023 i_pause in IDLE SHALL have no effect.
REQ-024 Count arithmetic SHALL be unsigned WIDTH-bit and never wrap below 0.

Reset
REQ-025 i_rst high at an edge SHALL set state IDLE, o_count=0, o_done=0, o_busy=0, latched N=0, mode=0, prescaler=0, including mid-count.

Configuration
REQ-026 With TIMER_PRESCALE_EN defined, a tick SHALL occur once every PRESCALE clocks in RUN; prescaler cleared on start, abort, reset; held in PAUSE; o_done latency N*PRESCALE clocks.
REQ-027 Without TIMER_PRESCALE_EN, every clock in RUN SHALL be a tick and PRESCALE SHALL be unused.

Structure
REQ-028 SHALL place the state enum (IDLE, RUN, PAUSE) and mode constants (MODE_ONESHOT=0, MODE_PERIODIC=1) in shared package lift_timer_pkg.
REQ-029 SHALL implement the prescaler as sub-module timer_prescaler (ports: clock, reset, clear, hold, tick out), instantiated only under TIMER_PRESCALE_EN.

Verification
REQ-030 No prescale, WIDTH=8: start N=5 mode 0 -> o_count 5,4,3,2,1,0; o_done single pulse 5 clocks after start; o_busy low next.
REQ-031 Periodic N=3: start, run 10 clocks -> o_done at clocks 3, 6, 9; o_count reloads to 3 after each.
REQ-032 Start N=10, pause at count 6 for 4 clocks, release -> o_count holds 6, o_done 14 clocks after start.
REQ-033 Start N=8, restart with N=8 at count 2 -> no o_done at original expiry; o_done 8 clocks after restart.
REQ-034 Start N=4 with i_start and i_abort same edge -> IDLE, o_count=0; start N=0 -> ignored; i_rst mid-count -> all outputs 0.
REQ-035 TIMER_PRESCALE_EN, PRESCALE=10, start N=3 -> o_done exactly 30 clocks after start.
